// File: rtl/ebus_arbiter_if.sv
// EBUS driver-side bundle: per-driver requests and data in, the shared bus and grant out.
interface ebus_arbiter_if #(
  parameter int N_DRV  = 13,
  parameter int DATA_W = 36
);
  logic [N_DRV-1:0]        req;
  logic [N_DRV*DATA_W-1:0] data_in;
  logic [DATA_W-1:0]       ebus_data;
  logic [N_DRV-1:0]        grant;

  modport master (output req, data_in, input ebus_data, grant);
  modport slave  (input req, data_in, output ebus_data, grant);
endinterface

// File: rtl/ebus_arbiter.sv
// EBUS arbiter: one-hot registered grant with fixed-priority or round-robin selection,
// hold timeout with per-driver lockout, and sticky conflict/timeout diagnostics.
module ebus_arbiter #(
  parameter int N_DRV   = 13,
  parameter int DATA_W  = 36,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             CROBAR_N,
  ebus_arbiter_if.slave    bus,
  input  logic             err_clr,
  output logic             conflict_err,
  output logic [7:0]       conflict_cnt,
  output logic             timeout_err
);
  localparam int IDX_W = (N_DRV > 1) ? $clog2(N_DRV) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
    inc_wrap = (v == IDX_W'(N_DRV - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W:0] pick(input logic [N_DRV-1:0] set,
                                          input logic [IDX_W-1:0] ptr);
    logic found;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_DRV; k++) begin
      int j;
      j = ((RR_MODE != 0) ? int'(ptr) : 0) + k;
      if (j >= N_DRV) j = j - N_DRV;
      if (!found && set[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    pick = {found, idx};
  endfunction

  logic [0:0]         state_p1, state_nx;
  logic [N_DRV-1:0]   grant_p1, grant_nx;
  logic [DATA_W-1:0]  data_p1, data_nx;
  logic [IDX_W-1:0]   owner_p1, owner_nx;
  logic [7:0]         hold_cnt, hold_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_nx;
  logic [N_DRV-1:0]   lockout, lock_nx;

  logic               owner_req, hold_ok, force_rel, multi_req;
  logic [N_DRV-1:0]   elig;
  logic [IDX_W:0]     win;

  assign owner_req = |(bus.req & grant_p1);
  assign hold_ok   = (state_p1 == OWNED) && owner_req && (hold_cnt < 8'(TIMEOUT - 1));
  assign force_rel = (state_p1 == OWNED) && owner_req && (hold_cnt >= 8'(TIMEOUT - 1));
  // A forcibly released owner is excluded from the same-edge re-arbitration.
  assign elig      = bus.req & ~lockout & ~(force_rel ? grant_p1 : '0);
  assign win       = pick(elig, rr_ptr);
  assign multi_req = |(bus.req & (bus.req - N_DRV'(1)));
  assign lock_nx   = (lockout & bus.req) | (force_rel ? grant_p1 : '0);

  always_comb begin
    state_nx = state_p1;
    grant_nx = grant_p1;
    owner_nx = owner_p1;
    hold_nx  = hold_cnt;
    rr_nx    = rr_ptr;
    data_nx  = '0;
    if (hold_ok) begin
      hold_nx = hold_cnt + 8'd1;
    end else begin
      hold_nx = '0;
      if (win[IDX_W]) begin
        state_nx = OWNED;
        owner_nx = win[IDX_W-1:0];
        grant_nx = N_DRV'(1) << win[IDX_W-1:0];
        rr_nx    = inc_wrap(win[IDX_W-1:0]);
      end else begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    end
    if (state_nx == OWNED)
      data_nx = bus.data_in[int'(owner_nx)*DATA_W +: DATA_W];
  end

  // Stage p1: registered grant/data and control state
  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state_p1     <= IDLE;
      grant_p1     <= '0;
      data_p1      <= '0;
      owner_p1     <= '0;
      hold_cnt     <= '0;
      rr_ptr       <= '0;
      lockout      <= '0;
      conflict_err <= 1'b0;
      conflict_cnt <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      grant_p1 <= grant_nx;
      data_p1  <= data_nx;
      owner_p1 <= owner_nx;
      hold_cnt <= hold_nx;
      rr_ptr   <= rr_nx;
      lockout  <= lock_nx;
      // A new event in the same cycle as err_clr takes precedence over the clear.
      if (multi_req) begin
        conflict_err <= 1'b1;
        conflict_cnt <= err_clr ? 8'd1 : sat_inc(conflict_cnt);
      end else if (err_clr) begin
        conflict_err <= 1'b0;
        conflict_cnt <= '0;
      end
      if (force_rel)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  assign bus.grant     = grant_p1;
  assign bus.ebus_data = data_p1;
endmodule

// File: tb/tb_ebus_arbiter.sv
// Scoreboard bench for ebus_arbiter: fixed-priority and round-robin instances, N_DRV=4, TIMEOUT=4.
module tb_ebus_arbiter;
  logic clk = 1'b0;
  logic CROBAR_N = 1'b0;
  logic clr_fp = 1'b0, clr_rr = 1'b0;
  logic cerr_fp, terr_fp, cerr_rr, terr_rr;
  logic [7:0] cnt_fp, cnt_rr;

  logic [35:0] d [4] = '{36'h000000AB0, 36'h123456789, 36'h222222222, 36'h333333333};

  ebus_arbiter_if #(.N_DRV(4), .DATA_W(36)) bus_fp ();
  ebus_arbiter_if #(.N_DRV(4), .DATA_W(36)) bus_rr ();

  ebus_arbiter #(.N_DRV(4), .DATA_W(36), .RR_MODE(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .CROBAR_N(CROBAR_N), .bus(bus_fp), .err_clr(clr_fp),
    .conflict_err(cerr_fp), .conflict_cnt(cnt_fp), .timeout_err(terr_fp));

  ebus_arbiter #(.N_DRV(4), .DATA_W(36), .RR_MODE(1), .TIMEOUT(4)) dut_rr (
    .clk(clk), .CROBAR_N(CROBAR_N), .bus(bus_rr), .err_clr(clr_rr),
    .conflict_err(cerr_rr), .conflict_cnt(cnt_rr), .timeout_err(terr_rr));

  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    bit          chk_bus;
    bit          chk_flg;
    logic [3:0]  grant;
    logic        cerr;
    logic [7:0]  cnt;
    logic        terr;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_asrt = 0;
  int n_fail = 0;
  event smp;

  function automatic logic [35:0] exp_data(input logic [3:0] g);
    exp_data = '0;
    for (int i = 0; i < 4; i++) if (g[i]) exp_data = d[i];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1 -> smp;
  end

  // Monitor: drain every expectation queued for the edge just sampled
  initial begin
    exp_t e;
    forever begin
      @smp;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_bus) begin
          check({e.name, ".grant"}, e.sel ? bus_rr.grant : bus_fp.grant, e.grant);
          check({e.name, ".data"}, e.sel ? bus_rr.ebus_data : bus_fp.ebus_data,
                exp_data(e.grant));
        end
        if (e.chk_flg) begin
          check({e.name, ".cerr"}, e.sel ? cerr_rr : cerr_fp, e.cerr);
          check({e.name, ".cnt"},  e.sel ? cnt_rr : cnt_fp, e.cnt);
          check({e.name, ".terr"}, e.sel ? terr_rr : terr_fp, e.terr);
        end
      end
    end
  end

  task automatic push(input bit sel, input bit cb, input bit cf, input logic [3:0] g,
                      input logic ce, input logic [7:0] cc, input logic te, input string nm);
    exp_t e;
    e.sel = sel; e.chk_bus = cb; e.chk_flg = cf; e.grant = g;
    e.cerr = ce; e.cnt = cc; e.terr = te; e.name = nm;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] r, input logic clr, input bit cb, input bit cf,
                     input logic [3:0] g, input logic ce, input logic [7:0] cc,
                     input logic te, input string nm);
    bus_fp.req = r;
    clr_fp = clr;
    if (cb || cf) push(1'b0, cb, cf, g, ce, cc, te, nm);
    @(posedge clk);
    #3;
  endtask

  task automatic cyc_rr(input logic [3:0] r, input logic [3:0] g, input string nm);
    bus_rr.req = r;
    push(1'b1, 1'b1, 1'b0, g, 1'b0, 8'd0, 1'b0, nm);
    @(posedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_fp.req = '0;
    bus_rr.req = '0;
    bus_fp.data_in = {d[3], d[2], d[1], d[0]};
    bus_rr.data_in = {d[3], d[2], d[1], d[0]};
    #2;
    push(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0, "reset_fp");
    push(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0, "reset_rr");
    -> smp;
    @(posedge clk);
    #3;
    CROBAR_N = 1'b1;

    // Round-robin rotation, each owner dropping req for one cycle
    cyc_rr(4'b1111, 4'b0001, "rr0");
    cyc_rr(4'b1110, 4'b0010, "rr1");
    cyc_rr(4'b1101, 4'b0100, "rr2");
    cyc_rr(4'b1011, 4'b1000, "rr3");
    cyc_rr(4'b0111, 4'b0001, "rr4");
    cyc_rr(4'b0000, 4'b0000, "rr_idle");

    // Single request and fixed-priority conflict with back-to-back handover
    cyc(4'b0010, 0, 1, 1, 4'b0010, 0, 8'd0, 0, "single");
    cyc(4'b0000, 0, 1, 1, 4'b0000, 0, 8'd0, 0, "single_rel");
    cyc(4'b1010, 0, 1, 1, 4'b0010, 1, 8'd1, 0, "conflict");
    cyc(4'b1000, 0, 1, 1, 4'b1000, 1, 8'd1, 0, "handover");
    cyc(4'b0000, 0, 1, 1, 4'b0000, 1, 8'd1, 0, "handover_rel");

    // Timeout: four cycles of ownership, then lockout until req0 drops
    for (int i = 0; i < 4; i++)
      cyc(4'b0001, 0, 1, 1, 4'b0001, 1, 8'd1, 0, "to_hold");
    cyc(4'b0001, 0, 1, 1, 4'b0000, 1, 8'd1, 1, "to_release");
    cyc(4'b0001, 0, 1, 1, 4'b0000, 1, 8'd1, 1, "to_locked1");
    cyc(4'b0001, 0, 1, 1, 4'b0000, 1, 8'd1, 1, "to_locked2");
    cyc(4'b0000, 0, 1, 1, 4'b0000, 1, 8'd1, 1, "to_drop");
    cyc(4'b0001, 0, 1, 1, 4'b0001, 1, 8'd1, 1, "to_rerise");
    cyc(4'b0000, 0, 1, 1, 4'b0000, 1, 8'd1, 1, "to_idle");
    cyc(4'b0000, 1, 1, 1, 4'b0000, 0, 8'd0, 0, "clr1");

    // Conflict and timeout together; forced release hands over to driver 1
    cyc(4'b0011, 0, 1, 1, 4'b0001, 1, 8'd1, 0, "ct_e1");
    cyc(4'b0011, 0, 1, 1, 4'b0001, 1, 8'd2, 0, "ct_e2");
    cyc(4'b0011, 0, 1, 1, 4'b0001, 1, 8'd3, 0, "ct_e3");
    cyc(4'b0011, 0, 1, 1, 4'b0001, 1, 8'd4, 0, "ct_e4");
    cyc(4'b0011, 0, 1, 1, 4'b0010, 1, 8'd5, 1, "ct_force");
    cyc(4'b0011, 0, 1, 1, 4'b0010, 1, 8'd6, 1, "ct_hold");
    cyc(4'b0000, 0, 1, 1, 4'b0000, 1, 8'd6, 1, "ct_idle");

    // Saturation of the conflict counter
    for (int i = 0; i < 299; i++)
      cyc(4'b1100, 0, 0, 0, 4'b0000, 0, 8'd0, 0, "sat_run");
    cyc(4'b1100, 0, 0, 1, 4'b0000, 1, 8'd255, 1, "sat_255");
    cyc(4'b0000, 0, 1, 1, 4'b0000, 1, 8'd255, 1, "sat_idle");
    cyc(4'b0000, 1, 1, 1, 4'b0000, 0, 8'd0, 0, "clr_alone");
    cyc(4'b0101, 1, 1, 1, 4'b0001, 1, 8'd1, 0, "clr_and_set");
    cyc(4'b0100, 0, 1, 1, 4'b0100, 1, 8'd1, 0, "own2");

    // Asynchronous reset between edges while driver 2 owns the bus
    CROBAR_N = 1'b0;
    #1;
    push(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0, "async_rst");
    -> smp;
    #1;
    CROBAR_N = 1'b1;
    cyc(4'b0100, 0, 1, 1, 4'b0100, 0, 8'd0, 0, "post_rst");
    cyc(4'b0000, 0, 1, 1, 4'b0000, 0, 8'd0, 0, "post_rst_rel");

    @(posedge clk);
    #3;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/ebus_arbiter.md
EBUS_ARBITER -- requirements
Module: ebus_arbiter

Interface
REQ-001 Parameter N_DRV, default 13: number of EBUS driver ports.
REQ-002 Parameter DATA_W, default 36: EBUS data width.
REQ-003 Parameter RR_MODE, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
REQ-004 Parameter TIMEOUT, default 16, legal range 2..255: maximum consecutive cycles one driver may hold the bus.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port CROBAR_N, input, 1: reset, asynchronous and active-low.
REQ-007 Port req, input, N_DRV: bit i set means driver i requests to drive EBUS.
REQ-008 Port data_in, input, N_DRV*DATA_W: driver i data in slice [i*DATA_W +: DATA_W].
REQ-009 Port err_clr, input, 1: synchronous clear of the error flags and the conflict counter.
REQ-010 Port ebus_data, output, DATA_W: registered EBUS data.
REQ-011 Port grant, output, N_DRV: registered one-hot or zero grant vector.
REQ-012 Port conflict_err, output, 1: sticky flag, set when two or more drivers request in the same cycle.
REQ-013 Port conflict_cnt, output, 8: saturating count of conflict cycles.
REQ-014 Port timeout_err, output, 1: sticky flag, set when a forced release occurs.

Function
REQ-015 The block SHALL have two states: IDLE (grant zero) and OWNED (grant one-hot).
REQ-016 The eligible set SHALL be req & ~lockout; the winner is chosen from the eligible set by RR_MODE.
REQ-017 In round-robin mode the search SHALL start at rr_ptr, ascend, and wrap from N_DRV-1 to 0.
- rr_ptr is set to owner+1 (mod N_DRV) at every grant.
REQ-018 IDLE: if the eligible set is non-empty at an edge, the winner SHALL be granted at that edge and the state becomes OWNED; hold_cnt is cleared to 0.
REQ-019 OWNED: while the owner's req stays high and hold_cnt < TIMEOUT-1, grant SHALL hold and hold_cnt SHALL increment.
REQ-020 OWNED, owner req low: on the same edge the grant SHALL pass to the winner of the remaining eligible set (back-to-back, no idle cycle), or go to IDLE if that set is empty.
REQ-021 OWNED, owner req high and hold_cnt == TIMEOUT-1: a forced release SHALL occur.
- timeout_err is set.
- The owner's lockout bit is set.
- Re-arbitration follows REQ-020 with the owner excluded.
REQ-022 A lockout bit SHALL clear on the first edge at which its req is sampled low.
REQ-023 At each edge ebus_data SHALL load data_in of the next-cycle grantee, or all zeros if the next grant is zero.
- ebus_data and grant are therefore aligned.
- Latency from req to grant/data is one cycle.
REQ-024 Any cycle with popcount(req) >= 2 SHALL set conflict_err and increment conflict_cnt.
- conflict_cnt saturates at 255.
- The raw req vector is counted, independent of lockout.
REQ-025 If err_clr and a new set event occur in the same cycle, set SHALL win.
- conflict_cnt becomes 1 in that case.
REQ-026 If a conflict and a timeout occur in the same cycle, both flags SHALL set.
REQ-027 grant SHALL never have more than one bit set.

Reset
REQ-028 While CROBAR_N is low, the following SHALL be forced asynchronously:
- state IDLE, grant 0, ebus_data 0
- conflict_err 0, conflict_cnt 0, timeout_err 0
- hold_cnt 0, rr_ptr 0, lockout 0
REQ-029 Reset asserted mid-ownership SHALL drop grant and ebus_data to zero immediately, without waiting for a clock.
REQ-030 After CROBAR_N rises, the first edge SHALL arbitrate as if from IDLE.

Verification (N_DRV=4, DATA_W=36, TIMEOUT=4)
REQ-031 Single request: req=0010, data1=36'h123456789 -> next cycle grant=0010, ebus_data=36'h123456789; conflict_err stays 0.
REQ-032 Fixed-priority conflict: req=1010 -> grant=0010, conflict_err=1, conflict_cnt=1; clear req1 -> next edge grant=1000 with no idle cycle.
REQ-033 Round-robin: req held at 1111, each owner dropping req after 1 cycle and re-requesting -> grants cycle 0001, 0010, 0100, 1000, 0001.
REQ-034 Timeout: req=0001 held for 6 cycles -> grant=0001 for exactly 4 cycles, then grant=0, timeout_err=1; no regrant until req0 drops and re-rises.
REQ-035 Saturation and clear: 300 conflict cycles -> conflict_cnt=255; err_clr alone -> 0; err_clr plus conflict in the same cycle -> conflict_cnt=1, conflict_err=1.
REQ-036 Reset mid-operation: grant=0100 and CROBAR_N pulsed low between edges -> grant and ebus_data read 0 before the next edge; all counters and flags read 0.
